truth_table_scanner: RTL
========================

Name: truth_table_scanner

Overview:
Sequential checker for the 4-input combinational exercise blocks (SoP/PoS and their minimized, NAND-only and NOR-only forms). It drives all 2^N input vectors into a combinational function and samples the function output for each vector. It builds the captured minterm mask and compares it bit-by-bit against an expected mask. It replaces the hand-read truth-table printout with a self-checking hardware reader.

Parameters:
N_INPUTS, 4, function input width; ENTRIES = 2**N_INPUTS vectors per scan
SETTLE_CYCLES, 1, cycles each vector is held before its sample cycle (0 allowed)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
start  input  1  request a scan; honoured only in IDLE
expected_mask  input  ENTRIES  bit i = expected f for vector i; latched on accepted start
abcd  output  N_INPUTS  vector driven to the function under test; MSB = a, LSB = d
f_in  input  1  function output, combinational from abcd
busy  output  1  high from the accepted start until the final sample edge
done  output  1  one-cycle pulse; scan complete
pass  output  1  captured_mask == latched expected; valid from done, held until next start
captured_mask  output  ENTRIES  bit i = f_in sampled while abcd == i
mismatch_count  output  N_INPUTS+1  number of differing bits, saturates at ENTRIES
first_fail  output  N_INPUTS  lowest vector index that mismatched
first_fail_valid  output  1  at least one mismatch recorded

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values: all outputs 0; state IDLE; index 0; settle counter 0.
- A reset asserted mid-scan aborts the scan at the next edge. No done pulse is produced, and all results are cleared to 0.
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE:
  - abcd = 0 and busy = 0.
  - When start = 1 at an edge E0:
    - latch expected_mask;
    - clear captured_mask, mismatch_count, first_fail, first_fail_valid and pass;
    - set index = 0 and busy = 1;
    - go to SETTLE, or go straight to SAMPLE when SETTLE_CYCLES = 0.
- SETTLE:
  - abcd = index, held stable.
  - Counts SETTLE_CYCLES cycles, then moves to SAMPLE.
- SAMPLE:
  - abcd = index.
  - At the end-of-cycle edge:
    - write captured_mask[index] = f_in;
    - if f_in != expected[index], increment mismatch_count;
    - if this is the first mismatch, also set first_fail = index and first_fail_valid = 1.
  - If index < ENTRIES-1: increment index, reload the settle counter, and go to SETTLE (or stay in SAMPLE when SETTLE_CYCLES = 0).
  - If index == ENTRIES-1, on the same edge:
    - done = 1 and busy = 0;
    - pass = (final mismatch count == 0);
    - go to IDLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - Vector i is sampled at edge E0 + (i+1)(SETTLE_CYCLES+1).
  - done is high for exactly the one cycle after edge E0 + ENTRIES(SETTLE_CYCLES+1).
- abcd changes only at edges, so f_in has at least one full cycle to settle before it is sampled.
- start while busy: ignored. Latched expected_mask and results are unaffected.
- start high on the done cycle: accepted, because the FSM is in IDLE. A new scan begins one cycle after done, with a single idle cycle between scans.
- Holding: expected_mask changes during a scan have no effect. All results hold after done until the next accepted start.
- Index: wraps never; the scan terminates at ENTRIES-1.
- Mask order: captured_mask[i] corresponds to {a,b,c,d} = i.

Test Plan:
1. Correct function, minterms 1,3,4,5,7,10,11,13,15, expected 0xACBA, SETTLE_CYCLES=1, start pulse -> abcd steps 0..15 every 2 cycles; done 32 cycles after start edge; captured 0xACBA, pass=1, mismatch_count=0, first_fail_valid=0.
2. Same expected mask 0xACBA, f_in tied 0 -> captured 0x0000, mismatch_count=9, first_fail=1, first_fail_valid=1, pass=0.
3. f_in = inverted correct function -> captured 0x5345, mismatch_count=16, first_fail=0, pass=0.
4. start re-pulsed mid-scan and expected_mask changed mid-scan -> results identical to scenario 1. Then start held high continuously -> second scan begins one cycle after done, and the results clear at that start.
5. rst_n low for one cycle while abcd=7 -> next edge all outputs 0, state IDLE, no done. A following start completes a full scan with correct results.
6. SETTLE_CYCLES=0, correct function -> abcd increments every cycle; done 16 cycles after start edge; pass=1.

Source files
------------

// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : truth_table_scanner
//  Purpose  : Self-checking truth-table reader for small combinational
//             functions. Steps every input vector onto abcd, holds it
//             for SETTLE_CYCLES cycles, then samples f_in for one cycle.
//             The samples form a captured minterm mask, which is compared
//             bit-by-bit against an expected mask latched at start.
//  Ports    : clk, rst_n          - clock, synchronous active-low reset
//             start               - request a scan (accepted only when idle)
//             expected_mask       - expected truth table, latched at start
//             abcd / f_in         - vector driven out / function response
//             busy, done          - scan in progress / one-cycle completion
//             pass                - captured == expected, valid from done
//             captured_mask       - bit i = f_in observed for vector i
//             mismatch_count      - number of differing bits
//             first_fail(_valid)  - lowest mismatching vector index
//  Revision : 1.0 - initial release
// ============================================================================
module truth_table_scanner #(
    parameter  int N_INPUTS      = 4,
    parameter  int SETTLE_CYCLES = 1,
    localparam int ENTRIES       = 2**N_INPUTS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ENTRIES-1:0]  expected_mask,
    output logic [N_INPUTS-1:0] abcd,
    input  logic                f_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ENTRIES-1:0]  captured_mask,
    output logic [N_INPUTS:0]   mismatch_count,
    output logic [N_INPUTS-1:0] first_fail,
    output logic                first_fail_valid
);

    // The settle counter counts down from SETTLE_CYCLES-1 to 0 so that the
    // SETTLE state lasts exactly SETTLE_CYCLES cycles. With SETTLE_CYCLES=0
    // the SETTLE state is never entered and the counter is inert.
    localparam int                CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  C_RELOAD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [N_INPUTS:0] C_SAT    = (N_INPUTS+1)'(ENTRIES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [N_INPUTS-1:0] r_index;
    logic [CNT_W-1:0]    r_settle_cnt;
    logic [ENTRIES-1:0]  r_expected;

    logic                w_accept;
    logic                w_sample;
    logic                w_last;
    logic                w_miss;
    logic [N_INPUTS:0]   w_count_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and per-cycle strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_sample     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_sample = 1'b1;
                // The index never wraps: the all-ones vector ends the scan.
                if (r_index == '1) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Comparison of the current sample against the latched expectation.
    assign w_miss       = f_in ^ r_expected[r_index];
    assign w_count_next = (w_miss && (mismatch_count != C_SAT)) ?
                          mismatch_count + 1'b1 : mismatch_count;

    // ------------------------------------------------------------------
    // Datapath: index, settle counter, expectation latch and results
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_index          <= '0;
            r_settle_cnt     <= '0;
            r_expected       <= '0;
            captured_mask    <= '0;
            mismatch_count   <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
            done             <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_expected       <= expected_mask;
                captured_mask    <= '0;
                mismatch_count   <= '0;
                first_fail       <= '0;
                first_fail_valid <= 1'b0;
                pass             <= 1'b0;
                r_index          <= '0;
                r_settle_cnt     <= C_RELOAD;
            end else if (r_state == ST_SETTLE) begin
                if (r_settle_cnt != '0) begin
                    r_settle_cnt <= r_settle_cnt - 1'b1;
                end
            end else if (w_sample) begin
                captured_mask[r_index] <= f_in;
                mismatch_count         <= w_count_next;
                if (w_miss && !first_fail_valid) begin
                    first_fail       <= r_index;
                    first_fail_valid <= 1'b1;
                end
                if (w_last) begin
                    done <= 1'b1;
                    pass <= (w_count_next == '0);
                end else begin
                    r_index      <= r_index + 1'b1;
                    r_settle_cnt <= C_RELOAD;
                end
            end
        end
    end

    // Both outputs derive only from registers, so abcd moves at edges only
    // and busy drops on the final sample edge.
    assign busy = (r_state != ST_IDLE);
    assign abcd = (r_state == ST_IDLE) ? '0 : r_index;

endmodule
`default_nettype wire
